// File: rtl/image_pipeline_ctrl.sv
// image_pipeline_ctrl
//   Frame sequencer and sole owner of the single-port image BRAM. Loads a
//   PIXELS-word frame from a valid/ready pixel stream into words 0..PIXELS-1,
//   runs the deskew engine (unless bypassed), then runs the SVM classifier and
//   pulses done. The BRAM port is muxed between loader, deskew and classifier
//   according to the registered state.
// Ports:
//   clk, reset (async, active-low)
//   start/bypass in, ready/done/frame_cnt out   : frame control + status
//   s_valid/s_data in, s_ready out               : pixel stream
//   dsk_start out, dsk_ready/dsk_* in            : deskew handshake + BRAM request
//   cls_start/cls_base out, cls_ready/cls_* in   : classifier handshake + read request
//   mem_address/mem_wdata/mem_en/mem_we out      : BRAM port
module image_pipeline_ctrl #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned PIXELS   = 784,
  parameter int unsigned DSK_BASE = 784
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bypass,
  output logic              ready,
  output logic              done,
  output logic [15:0]       frame_cnt,
  input  logic              s_valid,
  input  logic [WIDTH-1:0]  s_data,
  output logic              s_ready,
  output logic              dsk_start,
  input  logic              dsk_ready,
  input  logic [ADDR_W-1:0] dsk_address,
  input  logic [WIDTH-1:0]  dsk_wdata,
  input  logic              dsk_en,
  input  logic              dsk_we,
  output logic              cls_start,
  input  logic              cls_ready,
  output logic [ADDR_W-1:0] cls_base,
  input  logic [ADDR_W-1:0] cls_address,
  input  logic              cls_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_en,
  output logic              mem_we
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DSK_GO  = 3'd2,
    DSK_RUN = 3'd3,
    CLS_GO  = 3'd4,
    CLS_RUN = 3'd5,
    FIN     = 3'd6
  } state_t;

  localparam logic [9:0] LAST_PIX = 10'(PIXELS - 1);

  state_t      state_q, state_d;
  logic [9:0]  pix_cnt_q, pix_cnt_d;
  logic        bypass_q, bypass_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    bypass_d    = bypass_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bypass_d  = bypass;
          pix_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (s_valid) begin
          // Counter returns to 0 on the last pixel so it never exceeds PIXELS-1.
          if (pix_cnt_q == LAST_PIX) begin
            pix_cnt_d = '0;
            state_d   = bypass_q ? CLS_GO : DSK_GO;
          end else begin
            pix_cnt_d = pix_cnt_q + 10'd1;
          end
        end
      end
      DSK_GO:  state_d = DSK_RUN;
      DSK_RUN: if (dsk_ready) state_d = CLS_GO;
      CLS_GO:  state_d = CLS_RUN;
      CLS_RUN: if (cls_ready) state_d = FIN;
      FIN: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      bypass_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      bypass_q    <= bypass_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Moore outputs decoded from the registered state only.
  assign ready     = (state_q == IDLE);
  assign s_ready   = (state_q == LOAD);
  assign dsk_start = (state_q == DSK_GO);
  assign cls_start = (state_q == CLS_GO);
  assign done      = (state_q == FIN);
  assign frame_cnt = frame_cnt_q;
  assign cls_base  = bypass_q ? '0 : ADDR_W'(DSK_BASE);

  // BRAM port ownership; requesters outside their states are simply ignored.
  always_comb begin
    mem_address = '0;
    mem_wdata   = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      LOAD: begin
        if (s_valid) begin
          mem_address = ADDR_W'(pix_cnt_q);
          mem_wdata   = s_data;
          mem_en      = 1'b1;
          mem_we      = 1'b1;
        end
      end
      DSK_GO, DSK_RUN: begin
        mem_address = dsk_address;
        mem_wdata   = dsk_wdata;
        mem_en      = dsk_en;
        mem_we      = dsk_we;
      end
      CLS_GO, CLS_RUN: begin
        mem_address = cls_address;
        mem_en      = cls_en;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_image_pipeline_ctrl.sv
module tb_image_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, bypass;
  logic        ready, done;
  logic [15:0] frame_cnt;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        dsk_start, dsk_ready;
  logic [10:0] dsk_address;
  logic [15:0] dsk_wdata;
  logic        dsk_en, dsk_we;
  logic        cls_start, cls_ready;
  logic [10:0] cls_base, cls_address;
  logic        cls_en;
  logic [10:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_en, mem_we;

  image_pipeline_ctrl #(.WIDTH(16), .ADDR_W(11), .PIXELS(784), .DSK_BASE(784)) dut (
    .clk(clk), .reset(reset), .start(start), .bypass(bypass), .ready(ready),
    .done(done), .frame_cnt(frame_cnt), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .dsk_start(dsk_start), .dsk_ready(dsk_ready),
    .dsk_address(dsk_address), .dsk_wdata(dsk_wdata), .dsk_en(dsk_en),
    .dsk_we(dsk_we), .cls_start(cls_start), .cls_ready(cls_ready),
    .cls_base(cls_base), .cls_address(cls_address), .cls_en(cls_en),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_en(mem_en),
    .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned n_dsk = 0, n_cls = 0, n_done = 0;
  logic [15:0] exp_frames;
  logic [15:0] mem_model [2048];

  typedef struct {
    logic [10:0] a;
    logic [15:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  // Mux vectors applied while the deskew (phase 0) or classifier (phase 1) owns the port.
  typedef struct {
    logic        phase;
    logic [10:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_en, d_we;
    logic [10:0] c_addr;
    logic        c_en;
    logic        st;
    logic [10:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_en, e_we;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Write scoreboard: every BRAM write must match the next expected entry.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      if (dsk_start) n_dsk++;
      if (cls_start) n_cls++;
      if (done) n_done++;
      if (mem_en && mem_we) begin
        mem_model[mem_address] <= mem_wdata;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {5'd0, mem_address, mem_wdata}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_address), 32'(mon_e.a));
          chk("wr_data", 32'(mem_wdata), 32'(mon_e.d));
        end
      end
    end
  end

  task automatic apply_vecs(input logic ph);
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].phase == ph) begin
        dsk_address = vecs[i].d_addr;
        dsk_wdata   = vecs[i].d_wdata;
        dsk_en      = vecs[i].d_en;
        dsk_we      = vecs[i].d_we;
        cls_address = vecs[i].c_addr;
        cls_en      = vecs[i].c_en;
        start       = vecs[i].st;
        if (vecs[i].d_en && vecs[i].d_we && ph == 1'b0)
          exp_q.push_back('{vecs[i].d_addr, vecs[i].d_wdata});
        #1;
        chk($sformatf("vec%0d_addr", i), 32'(mem_address), 32'(vecs[i].e_addr));
        chk($sformatf("vec%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wdata));
        chk($sformatf("vec%0d_en", i), 32'(mem_en), 32'(vecs[i].e_en));
        chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].e_we));
        chk($sformatf("vec%0d_ready", i), 32'(ready), 0);
        chk($sformatf("vec%0d_cls_start", i), 32'(cls_start), 0);
        tick();
      end
    end
    start = 0; dsk_en = 0; dsk_we = 0; cls_en = 0;
  endtask

  task automatic run_frame(input bit byp, input bit gaps, input bit use_vecs);
    int unsigned hs, cyc, d0, c0, f0;
    chk("ready_idle", 32'(ready), 1);
    start = 1; bypass = byp;
    tick();
    start = 0; bypass = 0;
    d0 = n_dsk; c0 = n_cls; f0 = n_done;
    chk("s_ready_after_start", 32'(s_ready), 1);
    hs = 0; cyc = 0;
    while (hs < 784 && cyc < 3000) begin
      s_valid = gaps ? (cyc % 3 != 2) : 1'b1;
      s_data  = 16'h0100 + 16'(hs);
      if (s_valid) exp_q.push_back('{11'(hs), 16'h0100 + 16'(hs)});
      #1;
      chk("load_mem_en", 32'(mem_en), 32'(s_valid));
      @(posedge clk);
      if (s_valid) hs++;
      cyc++;
      @(negedge clk);
    end
    if (hs < 784) chk("load_timeout", hs, 784);
    s_valid = 0;
    #1;
    chk("dsk_start_after_last", 32'(dsk_start), byp ? 0 : 1);
    chk("cls_start_after_last", 32'(cls_start), byp ? 1 : 0);
    chk("s_ready_after_last", 32'(s_ready), 0);
    if (!byp) begin
      dsk_ready = 0;
      tick();
      chk("dsk_start_one_cycle", 32'(dsk_start), 0);
      if (use_vecs) apply_vecs(1'b0);
      for (int k = 0; k < 784; k++) begin
        dsk_en = 1; dsk_we = 1;
        dsk_address = 11'(784 + k);
        dsk_wdata   = 16'h2000 + 16'(k);
        exp_q.push_back('{11'(784 + k), 16'h2000 + 16'(k)});
        tick();
      end
      dsk_en = 0; dsk_we = 0; dsk_ready = 1;
      tick();
      chk("cls_start_after_dsk", 32'(cls_start), 1);
      chk("cls_base_dsk", 32'(cls_base), 784);
    end else begin
      chk("cls_base_bypass", 32'(cls_base), 0);
    end
    cls_ready = 0;
    tick();
    chk("cls_start_one_cycle", 32'(cls_start), 0);
    for (int j = 0; j < 10; j++) begin
      cls_en = 1; cls_address = 11'(j * 3);
      #1;
      chk("cls_mem_en", 32'(mem_en), 1);
      chk("cls_mem_we", 32'(mem_we), 0);
      chk("cls_mem_addr", 32'(mem_address), 32'(j * 3));
      tick();
    end
    if (use_vecs) apply_vecs(1'b1);
    cls_en = 0; cls_ready = 1;
    tick();
    chk("done_pulse", 32'(done), 1);
    exp_frames = exp_frames + 16'd1;
    tick();
    chk("done_low", 32'(done), 0);
    chk("ready_after_done", 32'(ready), 1);
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    chk("dsk_start_count", n_dsk - d0, byp ? 0 : 1);
    chk("cls_start_count", n_cls - c0, 1);
    chk("done_count", n_done - f0, 1);
    chk("writes_pending", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned bad;
    vecs[0] = '{1'b0, 11'h310, 16'hABCD, 1'b1, 1'b1, 11'd5,   1'b1, 1'b1, 11'h310, 16'hABCD, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 11'h7FF, 16'h0001, 1'b1, 1'b0, 11'd5,   1'b1, 1'b0, 11'h7FF, 16'h0001, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 11'h000, 16'hFFFF, 1'b0, 1'b0, 11'd5,   1'b1, 1'b1, 11'h000, 16'hFFFF, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 11'h123, 16'h5555, 1'b1, 1'b1, 11'd5,   1'b1, 1'b1, 11'd5,   16'h0000, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 11'h3FF, 16'hAAAA, 1'b1, 1'b1, 11'h62F, 1'b1, 1'b0, 11'h62F, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 11'h000, 16'h0000, 1'b0, 1'b0, 11'h400, 1'b0, 1'b0, 11'h400, 16'h0000, 1'b0, 1'b0};

    reset = 0; start = 0; bypass = 0; s_valid = 0; s_data = 0;
    dsk_ready = 1; dsk_address = 0; dsk_wdata = 0; dsk_en = 0; dsk_we = 0;
    cls_ready = 1; cls_address = 0; cls_en = 0;
    exp_frames = 0;
    @(negedge clk);
    tick(); tick();
    chk("rst_ready", 32'(ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_dsk_start", 32'(dsk_start), 0);
    chk("rst_cls_start", 32'(cls_start), 0);
    chk("rst_mem", {mem_en, mem_we, 3'd0, mem_address, mem_wdata}, 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_cls_base", 32'(cls_base), 784);
    reset = 1;
    tick();

    // Frame 1: gapped load, deskew, classifier, mux vectors incl. ignored start.
    run_frame(1'b0, 1'b1, 1'b1);
    bad = 0;
    for (int i = 0; i < 784; i++) if (mem_model[i] !== 16'h0100 + 16'(i)) bad++;
    chk("bram_image_words", bad, 0);
    bad = 0;
    for (int i = 0; i < 784; i++) if (mem_model[784 + i] !== 16'h2000 + 16'(i)) bad++;
    chk("bram_deskew_words", bad, 0);

    // Frame 2: bypass.
    run_frame(1'b1, 1'b0, 1'b0);

    // Reset mid-LOAD.
    start = 1; tick(); start = 0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; s_data = 16'h0100 + 16'(i);
      exp_q.push_back('{11'(i), 16'h0100 + 16'(i)});
      tick();
    end
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("midrst_ready", 32'(ready), 1);
      chk("midrst_s_ready", 32'(s_ready), 0);
      chk("midrst_mem", {mem_en, mem_we, 3'd0, mem_address, mem_wdata}, 0);
      chk("midrst_frame_cnt", 32'(frame_cnt), 0);
      tick();
    end
    s_valid = 0; reset = 1; exp_frames = 0;
    chk("midrst_pending", exp_q.size(), 0);
    tick();

    // Fresh frame after abort, bypass with gaps.
    run_frame(1'b1, 1'b1, 1'b0);

    // Counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    exp_frames = 16'hFFFF;
    run_frame(1'b1, 1'b0, 1'b0);
    chk("frame_cnt_wrap", 32'(frame_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/image_pipeline_ctrl.md
# image_pipeline_ctrl

Frame-level sequencer and single-port image BRAM owner for the digit-recognition accelerator. Accepts a 28x28 pixel stream into BRAM words 0..783, starts the deskew engine, and multiplexes the BRAM port to it until it finishes. It then hands the port to the SVM classifier and reports frame completion. It is the only block driving the BRAM address/control pins. Deskew and classifier access the BRAM only through this block.

## Interface
- WIDTH, 16, pixel / BRAM data width
- ADDR_W, 11, BRAM address width (2048 words)
- PIXELS, 784, pixels per frame
- DSK_BASE, 784, word address of the deskewed image
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; honoured only while ready=1
- bypass  in  1  skip deskew for this frame; sampled with start
- ready  out  1  controller in IDLE
- done  out  1  one-cycle pulse, frame complete
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0
- s_valid  in  1  input pixel valid
- s_data  in  WIDTH  input pixel
- s_ready  out  1  pixel accepted when s_valid&s_ready
- dsk_start  out  1  start pulse to deskew
- dsk_ready  in  1  deskew idle
- dsk_address  in  ADDR_W;  dsk_wdata  in  WIDTH;  dsk_en  in  1;  dsk_we  in  1  deskew BRAM request
- cls_start  out  1  start pulse to classifier
- cls_ready  in  1  classifier idle
- cls_base  out  ADDR_W  image base for classifier: 0 if bypass latched, else DSK_BASE
- cls_address  in  ADDR_W;  cls_en  in  1  classifier BRAM read request
- mem_address  out  ADDR_W;  mem_wdata  out  WIDTH;  mem_en  out  1;  mem_we  out  1  BRAM port
- BRAM read data is wired directly to deskew and classifier; not routed through this block.

## Operation
- States: IDLE, LOAD, DSK_GO, DSK_RUN, CLS_GO, CLS_RUN, FIN.
- IDLE: ready=1. On start: latch bypass, clear pix_cnt, go to LOAD. start in any other state is ignored.
- LOAD: s_ready=1. On each handshake: mem_en=mem_we=1, mem_address=pix_cnt, mem_wdata=s_data, pix_cnt++. The handshake at pix_cnt=PIXELS-1 exits to CLS_GO if bypass is latched, else DSK_GO. Cycles with s_valid=0 stall with mem_en=0.
- DSK_GO: dsk_start=1 for exactly one cycle, then DSK_RUN.
- DSK_RUN: BRAM port = deskew request, passed through combinationally (address, wdata, en, we). Exit to CLS_GO on the first cycle with dsk_ready=1.
- CLS_GO: cls_start=1 for one cycle, then CLS_RUN.
- CLS_RUN: mem_address=cls_address, mem_en=cls_en, mem_we=0 (classifier is read-only), mem_wdata=0. Exit to FIN when cls_ready=1.
- FIN: done=1, frame_cnt++, return to IDLE.
- Port ownership is decoded from the registered state only. In states not listed as owners, all mem_* are 0. The deskew port is owned in DSK_GO and DSK_RUN. The classifier port is owned in CLS_GO and CLS_RUN.
- Deskew and classifier requests outside their ownership states are dropped with no side effect.
- pix_cnt is 10 bits and never exceeds PIXELS-1.

## Timing
- Reset (asserted) values: state=IDLE, ready=1, done=0, s_ready=0, dsk_start=0, cls_start=0, mem_*=0, frame_cnt=0, pix_cnt=0, bypass latch=0, cls_base=DSK_BASE.
- Reset asserted mid-frame aborts immediately. There is no drain, and the BRAM contents are undefined.
- start to first s_ready: 1 cycle.
- Last pixel to dsk_start: 1 cycle. Last pixel to cls_start on bypass: 1 cycle.
- dsk_ready is sampled only from the cycle after dsk_start. It must be 0 on that cycle because deskew leaves idle one cycle after start. dsk_ready=1 there ends DSK_RUN immediately; this is legal but flags a stuck engine in test.
- cls_ready is handled the same way as dsk_ready.
- dsk_ready=1 to cls_start: 1 cycle. cls_ready=1 to done: 1 cycle. done to ready: 1 cycle.
- Minimum frame length: PIXELS + deskew run + classifier run + 5 cycles.
- s_ready, ready, dsk_start, cls_start and done are Moore outputs. mem_* are Mealy only through the pass-through of requester inputs.

## Test plan
- Reset check: hold reset=0 for 3 cycles mid-LOAD -> ready=1, all mem_*=0, frame_cnt=0, s_ready=0.
- Load with gaps: start, then 784 pixels of value 0x0100+i with s_valid low every 3rd cycle -> BRAM words 0..783 hold 0x0100..0x040F, exactly 784 writes, dsk_start pulses once, 1 cycle after the last handshake.
- Full frame with the real Deskew model plus a classifier stub (cls_ready low for 10 cycles) -> words 784..1567 are written only while in DSK_RUN, cls_base=784, one done pulse, frame_cnt=1.
- Bypass: start with bypass=1 -> no dsk_start, cls_start 1 cycle after the last pixel, cls_base=0, classifier write attempts (cls_en=1) produce mem_we=0.
- Ignored start and isolation: pulse start during DSK_RUN and drive cls_en=1 with cls_address=5 -> no state change, mem_address follows dsk_address only.
- Wrap: preload frame_cnt path by running frames until 0xFFFF -> the next done gives frame_cnt=0x0000.
